// File: rtl/cbx_cfg_pkg.sv
// Shared definitions for the X-channel connection block and its configuration
// chain: width derivation helpers, the pin-mux track mapping and the commit
// outcome encoding.
//
// Optional build macro: CBX_CFG_PARITY_EN (adds a parity check on commit).
package cbx_cfg_pkg;

   typedef enum logic [1:0] {
      CMT_IDLE,
      CMT_ACCEPT,
      CMT_REJECT
   } commit_e;

   // Smallest width w with 2**w >= value.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      while ((64'd1 << width) < 64'(value)) width++;
      return width;
   endfunction

   function automatic int unsigned sel_width(input int unsigned mux_size);
      return clog2(mux_size);
   endfunction

   function automatic int unsigned chain_length(input int unsigned num_pins,
                                                input int unsigned mux_size);
      return num_pins * sel_width(mux_size);
   endfunction

   // Track feeding input k of pin p. Inputs come in left/right pairs that share
   // a track; successive pairs step TRACK_STRIDE tracks apart, wrapping around.
   function automatic int unsigned track_index(input int unsigned pin,
                                               input int unsigned input_idx,
                                               input int unsigned stride,
                                               input int unsigned chan_width);
      return (pin + (input_idx >> 1) * stride) % chan_width;
   endfunction

endpackage

// File: rtl/cbx_cfg_chain.sv
// Double-buffered configuration chain for the connection block.
// Bits shift serially into a shadow register; a commit copies the shadow into
// the active register that drives the pin muxes, so live pins never see
// partially shifted data.
//
// Ports:
//   prog_clk, prog_reset_n  clock, asynchronous active-low reset
//   ccff_head               serial data in
//   ccff_en                 shift enable
//   cfg_commit              single-cycle commit request
//   cfg_parity              expected XOR of the shadow (CBX_CFG_PARITY_EN only)
//   active                  committed configuration word
//   ccff_tail               serial data out (last shadow bit)
//   cfg_valid               an accepted commit has happened since reset
//   cfg_err                 sticky: a commit was rejected since reset
//
// Optional build macro: CBX_CFG_PARITY_EN.
module cbx_cfg_chain
   import cbx_cfg_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 16
) (
   input  logic                 prog_clk,
   input  logic                 prog_reset_n,
   input  logic                 ccff_head,
   input  logic                 ccff_en,
   input  logic                 cfg_commit,
`ifdef CBX_CFG_PARITY_EN
   input  logic                 cfg_parity,
`endif
   output logic [CHAIN_LEN-1:0] active,
   output logic                 ccff_tail,
   output logic                 cfg_valid,
   output logic                 cfg_err
);

   localparam int unsigned CNT_W = clog2(CHAIN_LEN + 1);

   logic [CHAIN_LEN-1:0] shadow;
   logic [CHAIN_LEN-1:0] shadow_nxt;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     count_base;
   logic [CNT_W-1:0]     count_nxt;
   logic                 chain_full;
   logic                 parity_ok;
   commit_e              outcome;

   assign chain_full = (count == CNT_W'(CHAIN_LEN));

`ifdef CBX_CFG_PARITY_EN
   assign parity_ok = ((^shadow) == cfg_parity);
`else
   assign parity_ok = 1'b1;
`endif

   // Commit is judged on the pre-edge shadow and count, independent of any
   // shift happening in the same cycle.
   always_comb begin
      outcome = CMT_IDLE;
      if (cfg_commit) begin
         if (chain_full && parity_ok) outcome = CMT_ACCEPT;
         else                         outcome = CMT_REJECT;
      end
   end

   always_comb begin
      shadow_nxt = shadow;
      if (ccff_en) begin
         shadow_nxt[0] = ccff_head;
         for (int unsigned i = 1; i < CHAIN_LEN; i++) shadow_nxt[i] = shadow[i-1];
      end
   end

   // An accepted commit restarts the count; a simultaneous shift then counts
   // as the first bit of the next word. Shifting past full is pass-through.
   always_comb begin
      count_base = (outcome == CMT_ACCEPT) ? '0 : count;
      count_nxt  = count_base;
      if (ccff_en && (count_base != CNT_W'(CHAIN_LEN))) count_nxt = count_base + CNT_W'(1);
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         shadow    <= '0;
         active    <= '0;
         count     <= '0;
         cfg_valid <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         shadow <= shadow_nxt;
         count  <= count_nxt;
         case (outcome)
            CMT_ACCEPT: begin
               active    <= shadow;
               cfg_valid <= 1'b1;
            end
            CMT_REJECT: cfg_err <= 1'b1;
            default: ;
         endcase
      end
   end

   assign ccff_tail = shadow[CHAIN_LEN-1];

endmodule

// File: rtl/cbx_param_cfg.sv
// Parametrised X-channel connection block. The channel passes straight
// through left<->right; each of NUM_PINS grid pins is driven by a MUX_SIZE:1
// selector over channel tracks, configured from its own shift chain.
//
// Ports:
//   prog_clk, prog_reset_n       clock, asynchronous active-low reset
//   chanx_left_in/right_in       channel tracks entering from each side
//   chanx_left_out/right_out     pass-through of the opposite side
//   pin_out                      grid pin drives
//   ccff_head, ccff_en           chain serial in / shift enable
//   cfg_commit                   commit request
//   cfg_parity                   commit parity (CBX_CFG_PARITY_EN only)
//   ccff_tail                    chain serial out
//   cfg_valid, cfg_err           active config loaded / sticky rejected commit
//
// Optional build macro: CBX_CFG_PARITY_EN.
module cbx_param_cfg
   import cbx_cfg_pkg::*;
#(
   parameter int unsigned CHAN_WIDTH   = 30,
   parameter int unsigned NUM_PINS     = 4,
   parameter int unsigned MUX_SIZE     = 12,
   parameter int unsigned TRACK_STRIDE = 3
) (
   input  logic                  prog_clk,
   input  logic                  prog_reset_n,
   input  logic [CHAN_WIDTH-1:0] chanx_left_in,
   input  logic [CHAN_WIDTH-1:0] chanx_right_in,
   output logic [CHAN_WIDTH-1:0] chanx_left_out,
   output logic [CHAN_WIDTH-1:0] chanx_right_out,
   output logic [NUM_PINS-1:0]   pin_out,
   input  logic                  ccff_head,
   input  logic                  ccff_en,
   input  logic                  cfg_commit,
`ifdef CBX_CFG_PARITY_EN
   input  logic                  cfg_parity,
`endif
   output logic                  ccff_tail,
   output logic                  cfg_valid,
   output logic                  cfg_err
);

   localparam int unsigned SEL_W     = sel_width(MUX_SIZE);
   localparam int unsigned CHAIN_LEN = chain_length(NUM_PINS, MUX_SIZE);

   logic [CHAIN_LEN-1:0] active;

   assign chanx_left_out  = chanx_right_in;
   assign chanx_right_out = chanx_left_in;

   cbx_cfg_chain #(
      .CHAIN_LEN (CHAIN_LEN)
   ) u_chain (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .ccff_head    (ccff_head),
      .ccff_en      (ccff_en),
      .cfg_commit   (cfg_commit),
`ifdef CBX_CFG_PARITY_EN
      .cfg_parity   (cfg_parity),
`endif
      .active       (active),
      .ccff_tail    (ccff_tail),
      .cfg_valid    (cfg_valid),
      .cfg_err      (cfg_err)
   );

   for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
      logic [MUX_SIZE-1:0] mux_in;
      logic [SEL_W-1:0]    sel;
      logic                pin;

      for (genvar k = 0; k < MUX_SIZE; k++) begin : g_in
         localparam int unsigned TRK = track_index(p, k, TRACK_STRIDE, CHAN_WIDTH);
         if ((k % 2) == 0) begin : g_left
            assign mux_in[k] = chanx_left_in[TRK];
         end else begin : g_right
            assign mux_in[k] = chanx_right_in[TRK];
         end
      end

      assign sel = active[p*SEL_W +: SEL_W];

      // Out-of-range selects match no input and fall through to 0.
      always_comb begin
         pin = 1'b0;
         if (cfg_valid) begin
            for (int unsigned k = 0; k < MUX_SIZE; k++) begin
               if (sel == SEL_W'(k)) pin = mux_in[k];
            end
         end
      end

      assign pin_out[p] = pin;
   end

endmodule

// File: tb/tb_cbx_param_cfg.sv
module tb_cbx_param_cfg;

   logic        prog_clk = 1'b0;
   logic        prog_reset_n;
   logic [29:0] chanx_left_in;
   logic [29:0] chanx_right_in;
   logic [29:0] chanx_left_out;
   logic [29:0] chanx_right_out;
   logic [3:0]  pin_out;
   logic        ccff_head;
   logic        ccff_en;
   logic        cfg_commit;
   logic        ccff_tail;
   logic        cfg_valid;
   logic        cfg_err;
`ifdef CBX_CFG_PARITY_EN
   logic        cfg_parity;
   logic        par_force_en;
   logic        par_force_val;
`endif

   typedef struct {
      string       name;
      logic [15:0] cfg;
      logic [29:0] left;
      logic [29:0] right;
      logic [3:0]  exp_pin;
   } vec_t;

   vec_t        vecs[9];
   logic [3:0]  exp_q[$];
   logic [15:0] mshadow;
   logic [3:0]  prev;
   int          tests    = 0;
   int          failures = 0;

   always #5 prog_clk = ~prog_clk;

   cbx_param_cfg #(
      .CHAN_WIDTH   (30),
      .NUM_PINS     (4),
      .MUX_SIZE     (12),
      .TRACK_STRIDE (3)
   ) dut (
      .prog_clk        (prog_clk),
      .prog_reset_n    (prog_reset_n),
      .chanx_left_in   (chanx_left_in),
      .chanx_right_in  (chanx_right_in),
      .chanx_left_out  (chanx_left_out),
      .chanx_right_out (chanx_right_out),
      .pin_out         (pin_out),
      .ccff_head       (ccff_head),
      .ccff_en         (ccff_en),
      .cfg_commit      (cfg_commit),
`ifdef CBX_CFG_PARITY_EN
      .cfg_parity      (cfg_parity),
`endif
      .ccff_tail       (ccff_tail),
      .cfg_valid       (cfg_valid),
      .cfg_err         (cfg_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic shift_bit(input logic b);
      ccff_head = b;
      ccff_en   = 1'b1;
      tick();
      ccff_en   = 1'b0;
      mshadow   = {mshadow[14:0], b};
   endtask

   task automatic shift_bits(input logic [15:0] w, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) shift_bit(w[i]);
   endtask

   task automatic set_parity();
`ifdef CBX_CFG_PARITY_EN
      cfg_parity = par_force_en ? par_force_val : (^mshadow);
`endif
   endtask

   task automatic commit();
      set_parity();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   task automatic commit_shift(input logic b);
      set_parity();
      cfg_commit = 1'b1;
      ccff_head  = b;
      ccff_en    = 1'b1;
      tick();
      cfg_commit = 1'b0;
      ccff_en    = 1'b0;
      mshadow    = {mshadow[14:0], b};
   endtask

   task automatic expect_pins(input logic [3:0] e);
      exp_q.push_back(e);
   endtask

   task automatic compare_pins(input string name);
      logic [3:0] e;
      if (exp_q.size() == 0) begin
         tests++;
         failures++;
         $display("FAIL %s: actual=%0h required=<scoreboard empty>", name, pin_out);
      end else begin
         e = exp_q.pop_front();
         check(name, 32'(pin_out), 32'(e));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{"sel5_left",     16'h0005, 30'h0000000E, 30'h00000000, 4'b1110};
      vecs[1] = '{"sel5_right6",   16'h0005, 30'h00000000, 30'h00000040, 4'b0001};
      vecs[2] = '{"sel5_inverted", 16'h0005, 30'h3FFFFFF1, 30'h3FFFFFBF, 4'b0000};
      vecs[3] = '{"mixed_all1",    16'hBA18, 30'h00021000, 30'h00040002, 4'b1111};
      vecs[4] = '{"mixed_part",    16'hBA18, 30'h00020000, 30'h00000002, 4'b0110};
      vecs[5] = '{"sel13_zero",    16'h000D, 30'h0000000E, 30'h3FFFFFFF, 4'b1110};
      vecs[6] = '{"sel12_zero",    16'h0C00, 30'h3FFFFFFF, 30'h3FFFFFFF, 4'b1011};
      vecs[7] = '{"sel15_all",     16'hFFFF, 30'h3FFFFFFF, 30'h3FFFFFFF, 4'b0000};
      vecs[8] = '{"sel11_right15", 16'h000B, 30'h00000000, 30'h00008000, 4'b0001};

      prog_reset_n   = 1'b0;
      chanx_left_in  = 30'h3FFFFFFF;
      chanx_right_in = 30'h3FFFFFFF;
      ccff_head      = 1'b1;
      ccff_en        = 1'b0;
      cfg_commit     = 1'b0;
      mshadow        = '0;
`ifdef CBX_CFG_PARITY_EN
      cfg_parity     = 1'b0;
      par_force_en   = 1'b0;
      par_force_val  = 1'b0;
`endif

      // Reset held while the chain is clocked.
      for (int i = 0; i < 6; i++) begin
         ccff_en = i[0];
         tick();
      end
      ccff_en = 1'b0;
      expect_pins(4'b0000);
      compare_pins("reset_pins");
      check("reset_valid", 32'(cfg_valid), 32'd0);
      check("reset_tail",  32'(ccff_tail), 32'd0);
      check("reset_err",   32'(cfg_err),   32'd0);
      @(negedge prog_clk);
      prog_reset_n = 1'b1;

      // Commit one bit short is rejected; the full word is then accepted.
      chanx_left_in  = 30'h0000000E;
      chanx_right_in = 30'h00000040;
      shift_bits(16'h0005, 15, 1);
      commit();
      check("short_err",   32'(cfg_err),   32'd1);
      check("short_valid", 32'(cfg_valid), 32'd0);
      expect_pins(4'b0000);
      compare_pins("short_pins");
      shift_bits(16'h0005, 0, 0);
      commit();
      check("full_valid", 32'(cfg_valid), 32'd1);
      check("full_err",   32'(cfg_err),   32'd1);
      expect_pins(4'b1111);
      compare_pins("full_pins");

      // Table: shifting a new word leaves pins alone until its commit.
      prev = 4'b1111;
      for (int i = 0; i < 9; i++) begin
         shift_bits(vecs[i].cfg, 15, 0);
         expect_pins(prev);
         compare_pins({vecs[i].name, "_hold"});
         check({vecs[i].name, "_tail"}, 32'(ccff_tail), 32'(vecs[i].cfg[15]));
         chanx_left_in  = vecs[i].left;
         chanx_right_in = vecs[i].right;
         commit();
         expect_pins(vecs[i].exp_pin);
         compare_pins(vecs[i].name);
         check({vecs[i].name, "_valid"},   32'(cfg_valid),       32'd1);
         check({vecs[i].name, "_lpass"},   32'(chanx_left_out),  32'(vecs[i].right));
         check({vecs[i].name, "_rpass"},   32'(chanx_right_out), 32'(vecs[i].left));
         prev = vecs[i].exp_pin;
      end

      // Commit and shift in the same cycle: new word starts at count 1.
      chanx_left_in  = 30'h0000000E;
      chanx_right_in = 30'h00000000;
      shift_bits(16'h0005, 15, 0);
      commit_shift(1'b1);
      expect_pins(4'b1110);
      compare_pins("cs_accept");
      shift_bits(16'hFFF0, 14, 1);
      commit();
      expect_pins(4'b1110);
      compare_pins("cs_count15_reject");
      shift_bits(16'hFFF0, 0, 0);
      commit();
      expect_pins(4'b0000);
      compare_pins("cs_count16_accept");

      // Reset in the middle of a cycle drops outputs without a clock edge.
      shift_bits(16'h0005, 15, 0);
      commit();
      expect_pins(4'b1110);
      compare_pins("pre_reset_pins");
      shift_bits(16'hFFFF, 15, 0);
      shift_bit(1'b1);
      check("passthru_tail", 32'(ccff_tail), 32'd1);
      #2;
      prog_reset_n = 1'b0;
      #1;
      expect_pins(4'b0000);
      compare_pins("async_reset_pins");
      check("async_reset_valid", 32'(cfg_valid), 32'd0);
      check("async_reset_err",   32'(cfg_err),   32'd0);
      check("async_reset_tail",  32'(ccff_tail), 32'd0);
      #2;
      prog_reset_n = 1'b1;
      mshadow = '0;
      shift_bits(16'h0005, 15, 5);
      commit();
      check("post_reset_short_valid", 32'(cfg_valid), 32'd0);
      shift_bits(16'h0005, 4, 0);
      commit();
      check("post_reset_valid", 32'(cfg_valid), 32'd1);
      expect_pins(4'b1110);
      compare_pins("post_reset_pins");

`ifdef CBX_CFG_PARITY_EN
      prog_reset_n = 1'b0;
      #2;
      prog_reset_n = 1'b1;
      mshadow = '0;
      chanx_left_in  = 30'h0000000E;
      chanx_right_in = 30'h00000200;
      shift_bits(16'h0007, 15, 0);
      par_force_en  = 1'b1;
      par_force_val = 1'b0;
      commit();
      check("parity_bad_err",   32'(cfg_err),   32'd1);
      check("parity_bad_valid", 32'(cfg_valid), 32'd0);
      par_force_val = 1'b1;
      commit();
      check("parity_ok_valid", 32'(cfg_valid), 32'd1);
      expect_pins(4'b1111);
      compare_pins("parity_ok_pins");
      par_force_en = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
